// File: rtl/key_onehot_scanner.sv
// Debounced 8-key scanner: accepts one stable one-hot key and emits it as a registered one-hot code.
// Optional lowest-index priority for multi-key input is enabled by defining KEY_PRIORITY_EN.
module key_onehot_scanner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keys,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_hold;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_busy;

    logic [7:0] w_cand;
    logic       w_cand_vld;
    logic [1:0] w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_hold_nxt;
    logic [7:0] w_data_nxt;
    logic       w_valid_nxt;

`ifdef KEY_PRIORITY_EN
    // Two's-complement trick isolates the lowest set bit.
    assign w_cand = r_sync2 & (~r_sync2 + 8'd1);
`else
    assign w_cand = ((r_sync2 & (r_sync2 - 8'd1)) == 8'd0) ? r_sync2 : 8'd0;
`endif
    assign w_cand_vld = (w_cand != 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cand_vld) begin
                    w_hold_nxt  = w_cand;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (w_cand_vld && (w_cand == r_hold)) begin
                    if (r_cnt == CNT_LAST) begin
                        w_data_nxt  = r_hold;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_PRESSED;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PRESSED: begin
                // Any held or changed key is ignored until every line is released.
                if (r_sync2 == 8'd0) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_RELEASE;
                end
            end
            default: begin
                if (r_sync2 != 8'd0) begin
                    w_cnt_nxt = 8'd0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 8'd0;
            r_sync2 <= 8'd0;
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_hold  <= 8'd0;
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= keys;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule

// File: tb/tb_key_onehot_scanner.sv
// Directed bench for key_onehot_scanner: default-debounce instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_key_onehot_scanner;

    logic       clk;
    logic       rst;
    logic [7:0] keys;
    logic [7:0] keys1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic [7:0] data1;
    logic       valid1;
    logic       busy1;

    int checks;
    int failures;

    key_onehot_scanner dut (
        .clk   (clk),
        .rst   (rst),
        .keys  (keys),
        .data  (data),
        .valid (valid),
        .busy  (busy)
    );

    key_onehot_scanner #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .keys  (keys1),
        .data  (data1),
        .valid (valid1),
        .busy  (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] enc8(input logic [7:0] d);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic eb, input logic [7:0] ed);
        checks++;
        assert (valid === ev) else begin
            failures++;
            $error("FAIL %s valid obs=%b exp=%b", tag, valid, ev);
        end
        checks++;
        assert (busy === eb) else begin
            failures++;
            $error("FAIL %s busy obs=%b exp=%b", tag, busy, eb);
        end
        checks++;
        assert (data === ed) else begin
            failures++;
            $error("FAIL %s data obs=%h exp=%h", tag, data, ed);
        end
        checks++;
        assert ($onehot0(data) === 1'b1) else begin
            failures++;
            $error("FAIL %s data_onehot obs=%h exp=onehot0", tag, data);
        end
    endtask

    task automatic chk1(input string tag, input logic ev, input logic [7:0] ed);
        checks++;
        assert (valid1 === ev) else begin
            failures++;
            $error("FAIL %s valid1 obs=%b exp=%b", tag, valid1, ev);
        end
        checks++;
        assert (data1 === ed) else begin
            failures++;
            $error("FAIL %s data1 obs=%h exp=%h", tag, data1, ed);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        keys     = 8'h00;
        keys1    = 8'h00;
        step();
        step();
        chk("reset", 1'b0, 1'b0, 8'h00);
        chk1("reset1", 1'b0, 8'h00);
        rst = 1'b0;

        // Single key held: valid pulse at edge 7, busy from edge 3.
        for (int k = 1; k <= 20; k++) begin
            keys = 8'h04;
            step();
            chk($sformatf("press04_k%0d", k), k == 7, k >= 3, (k >= 7) ? 8'h04 : 8'h00);
        end
        for (int k = 1; k <= 8; k++) begin
            keys = 8'h00;
            step();
            chk($sformatf("rel04_k%0d", k), 1'b0, k < 7, 8'h04);
        end

        // Short bounce of 4 samples is rejected.
        for (int k = 1; k <= 10; k++) begin
            keys = (k <= 4) ? 8'h10 : 8'h00;
            step();
            chk($sformatf("bounce10_k%0d", k), 1'b0, (k >= 3) && (k <= 6), 8'h04);
        end

        // Accept 01, ignore 03 while pressed, glitchy release.
        for (int k = 1; k <= 28; k++) begin
            if (k <= 10)      keys = 8'h01;
            else if (k <= 15) keys = 8'h03;
            else if (k <= 17) keys = 8'h00;
            else if (k == 18) keys = 8'h01;
            else              keys = 8'h00;
            step();
            chk($sformatf("press01_k%0d", k), k == 7, (k >= 3) && (k <= 23),
                (k >= 7) ? 8'h01 : 8'h04);
        end

        // Two keys at once.
        for (int k = 1; k <= 15; k++) begin
            keys = 8'h28;
            step();
`ifdef KEY_PRIORITY_EN
            chk($sformatf("multi28_k%0d", k), k == 7, k >= 3, (k >= 7) ? 8'h08 : 8'h01);
`else
            chk($sformatf("multi28_k%0d", k), 1'b0, 1'b0, 8'h01);
`endif
        end
        keys = 8'h00;
        for (int k = 1; k <= 10; k++) step();

        // Reset mid-debounce discards the press; held key is re-accepted afterwards.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_pre80", 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            keys = 8'h80;
            rst  = (k == 6);
            step();
            chk($sformatf("rst80_k%0d", k), k == 13, ((k >= 3) && (k <= 5)) || (k >= 9),
                (k >= 13) ? 8'h80 : 8'h00);
        end
        rst = 1'b0;

        // Minimum debounce instance: valid at edge 4, encoder sees index 1.
        for (int k = 1; k <= 6; k++) begin
            keys1 = 8'h02;
            step();
            chk1($sformatf("d1_k%0d", k), k == 4, (k >= 4) ? 8'h02 : 8'h00);
            if (k == 4) begin
                checks++;
                assert (enc8(data1) === 3'b001) else begin
                    failures++;
                    $error("FAIL d1_enc obs=%b exp=%b", enc8(data1), 3'b001);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_onehot_scanner.md
KEY_ONEHOT_SCANNER -- requirements
Module: key_onehot_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive stable samples that qualify a press or release; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port keys  input  8  raw asynchronous key lines; active-high; bit i = key i.
REQ-005 SHALL have port data  output  8  registered one-hot code of the last accepted key; feeds the 8-to-3 encoder stage directly.
REQ-006 SHALL have port valid  output  1  one-cycle pulse when data is updated with a newly accepted key.
REQ-007 SHALL have port busy  output  1  high whenever the state machine is not in IDLE.

Function
REQ-008 SHALL pass keys through a two-flop synchronizer; only the synchronized value (keys_s) is used internally.
REQ-009 SHALL define the candidate as keys_s when keys_s has exactly one bit set; otherwise no candidate (subject to REQ-024).
REQ-010 SHALL implement the states IDLE, DEBOUNCE, PRESSED and RELEASE, with an 8-bit stability counter cnt.
REQ-011 In IDLE, SHALL capture a valid candidate into a hold register, clear cnt and enter DEBOUNCE; SHALL otherwise remain in IDLE.
REQ-012 In DEBOUNCE, a candidate equal to the hold register SHALL do one of two things:
- if cnt == DEBOUNCE_CYCLES-1: load data from the hold register, assert valid for that one cycle, and enter PRESSED;
- otherwise: increment cnt.
REQ-013 In DEBOUNCE, any mismatch (different key, multiple keys or no key) SHALL return the machine to IDLE with no valid and data unchanged.
REQ-014 Latency: with keys stable from before rising edge 1, valid and the new data SHALL appear after edge DEBOUNCE_CYCLES+3 (edge 7 for the default).
REQ-015 In PRESSED, SHALL ignore all nonzero keys_s values, including a second key or a key change, and SHALL generate no valid.
REQ-016 In PRESSED, keys_s == 0 SHALL clear cnt and enter RELEASE.
REQ-017 In RELEASE, keys_s == 0 SHALL increment cnt and enter IDLE once cnt == DEBOUNCE_CYCLES-1; any nonzero keys_s SHALL clear cnt and remain in RELEASE.
REQ-018 data SHALL hold its value between acceptances; valid SHALL never be high on two consecutive cycles.
REQ-019 busy SHALL be a registered decode: high in DEBOUNCE, PRESSED and RELEASE, low in IDLE.
REQ-020 data SHALL always be 8'h00 or exactly one-hot; no other value is legal.

Reset
REQ-021 While rst is high at a rising edge, SHALL set state=IDLE, cnt=0, hold register=0, synchronizer flops=0, data=8'h00, valid=0 and busy=0.
REQ-022 rst asserted mid-operation, in any state including the cycle valid would fire, SHALL take priority, and the press in progress SHALL be discarded.
REQ-023 After rst deasserts, a key held continuously SHALL be treated as a new press and accepted per REQ-014.

Configuration
REQ-024 Macro KEY_PRIORITY_EN: when defined, a multi-bit keys_s SHALL yield the lowest-index set bit as the candidate; when undefined, multi-bit keys_s yields no candidate and such presses are never accepted.

Verification
REQ-025 Default parameter, rst pulse then keys=8'h04 held 20 cycles -> valid single pulse at edge 7 after the change, data=8'h04, busy high from edge 3.
REQ-026 keys=8'h10 for 4 cycles then 8'h00 (bounce shorter than debounce) -> no valid, data unchanged, machine back in IDLE.
REQ-027 keys=8'h01 accepted, then 8'h03 while in PRESSED -> no second valid; then release: keys=8'h00 for 2 cycles, 8'h01 for 1 cycle, 8'h00 for 6 cycles -> stays in RELEASE until 4 consecutive zero samples, then IDLE.
REQ-028 keys=8'h28 held: without KEY_PRIORITY_EN -> no valid ever; with KEY_PRIORITY_EN -> valid once, data=8'h08.
REQ-029 keys=8'h80 held and rst asserted at edge 6 for one cycle -> no valid, data=8'h00, then valid at 7 edges after rst deasserts with data=8'h80.
REQ-030 DEBOUNCE_CYCLES=1, keys=8'h02 -> valid at edge 4 and data=8'h02; downstream encoder output observed as 3'b001.
